// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction memory geometry and the program loader state encoding.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_HI   = 3'd1,
    S_RX_LO   = 3'd2,
    S_WRITE   = 3'd3,
    S_RX_CSUM = 3'd4,
    S_DONE    = 3'd5
  } loader_state_t;

  function automatic logic [7:0] csum_update(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Writer side of the instruction memory: assembles big-endian words from a byte stream,
// writes DEPTH consecutive words, verifies a trailing XOR checksum and holds the CPU meanwhile.
module program_loader
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;
  logic              xfer;
  logic              csum_bad;

  // Handshake and status strobes depend on state only, so no input reaches an output.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      S_RX_HI, S_RX_LO, S_RX_CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      default: begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        mem_we     = 1'b0;
      end
    endcase
  end

  assign xfer     = byte_valid && byte_ready;
  assign csum_bad = (byte_data != csum_q);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RX_HI;
          addr_d  = '0;
          csum_d  = 8'h00;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RX_HI: begin
        if (xfer) begin
          hi_d    = byte_data;
          csum_d  = csum_update(csum_q, byte_data);
          state_d = S_RX_LO;
        end else begin
          state_d = S_RX_HI;
        end
      end
      S_RX_LO: begin
        if (xfer) begin
          mem_wdata_d = {hi_q, byte_data};
          mem_addr_d  = addr_q;
          csum_d      = csum_update(csum_q, byte_data);
          state_d     = S_WRITE;
        end else begin
          state_d = S_RX_LO;
        end
      end
      S_WRITE: begin
        // The word at LAST_ADDR ends the payload; addr never wraps.
        if (addr_q == LAST_ADDR) begin
          state_d = S_RX_CSUM;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RX_HI;
        end
      end
      S_RX_CSUM: begin
        if (xfer) begin
          error_d = csum_bad;
          hold_d  = csum_bad;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RX_CSUM;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      csum_q      <= 8'h00;
      hi_q        <= 8'h00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      hi_q        <= hi_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      hold_q      <= hold_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_hold  = hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader: full loads, checksum errors, gaps,
// pre-start bytes, start during a load and reset in the middle of a load.
module tb_program_loader;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]        hi;
    logic [7:0]        lo;
    logic [ADDR_W-1:0] exp_addr;
    logic [15:0]       exp_data;
  } vec_t;

  vec_t tab [DEPTH];
  logic [ADDR_W+DATA_W-1:0] wr_q[$];

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Record every memory write; the loader must never offer ready in a write cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},     32'd0);
    chk({tag, "_addr"},  {28'd0, mem_addr},   32'd0);
    chk({tag, "_wdata"}, {16'd0, mem_wdata},  32'd0);
    chk({tag, "_hold"},  {31'd0, cpu_hold},   32'd0);
    chk({tag, "_busy"},  {31'd0, busy},       32'd0);
    chk({tag, "_done"},  {31'd0, done},       32'd0);
    chk({tag, "_error"}, {31'd0, error},      32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the byte has been taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int t;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout actual=ready_low required=ready_high byte=%0h", b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [7:0] hi0, input logic [7:0] csum,
                          input int max_gap, input int mid_start, input logic exp_err);
    for (int i = 0; i < DEPTH; i++) begin
      tab[i].hi       = (i == 0) ? hi0 : 8'h12;
      tab[i].lo       = 8'(i);
      tab[i].exp_addr = ADDR_W'(i);
      tab[i].exp_data = (i == 0) ? {hi0, 8'h00} : 16'h1200 + 16'(i);
    end
    wr_q.delete();
    pulse_start();
    chk({tag, "_busy_start"}, {31'd0, busy},     32'd1);
    chk({tag, "_hold_start"}, {31'd0, cpu_hold}, 32'd1);
    chk({tag, "_done_clr"},   {31'd0, done},     32'd0);
    chk({tag, "_err_clr"},    {31'd0, error},    32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(tab[i].hi, max_gap);
      send_byte(tab[i].lo, max_gap);
      if (i == mid_start) pulse_start();
    end
    chk({tag, "_hold_before_csum"}, {31'd0, cpu_hold}, 32'd1);
    send_byte(csum, max_gap);
    chk({tag, "_done"},  {31'd0, done},     32'd1);
    chk({tag, "_error"}, {31'd0, error},    {31'd0, exp_err});
    chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, exp_err});
    chk({tag, "_busy"},  {31'd0, busy},     32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_nwrites"}, 32'(wr_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < wr_q.size(); i++) begin
      chk({tag, "_waddr"}, {28'd0, wr_q[i][ADDR_W+DATA_W-1:DATA_W]}, {28'd0, tab[i].exp_addr});
      chk({tag, "_wdata"}, {16'd0, wr_q[i][DATA_W-1:0]},             {16'd0, tab[i].exp_data});
    end
  endtask

  initial begin
    #3 rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_load("clean", 8'h12, 8'h00, 0, -1, 1'b0);
    run_load("badsum", 8'h12, 8'h5A, 0, -1, 1'b1);
    run_load("recover", 8'h12, 8'h00, 0, -1, 1'b0);
    run_load("gaps", 8'h12, 8'h00, 5, -1, 1'b0);

    // A byte offered while idle must wait and become the first hi byte.
    wr_q.delete();
    byte_valid = 1'b1;
    byte_data  = 8'hAB;
    repeat (3) begin
      @(negedge clk);
      chk("prestart_ready", {31'd0, byte_ready}, 32'd0);
    end
    chk("prestart_nowrite", 32'(wr_q.size()), 32'd0);
    run_load("prestart", 8'hAB, 8'hB9, 0, -1, 1'b0);

    run_load("midstart", 8'h12, 8'h00, 2, 5, 1'b0);

    // Reset while word 7's lo byte is being awaited.
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send_byte(8'h12, 0);
      send_byte(8'(i), 0);
    end
    send_byte(8'h12, 0);
    chk("midrst_in_lo_ready", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b1;
    byte_data  = 8'h07;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_nwrites", 32'(wr_q.size()), 32'd7);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    run_load("reload", 8'h12, 8'h00, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
